// File: rtl/hall_commutation_decoder_if.sv
// Hall sensor input and rotor-state outputs of the commutation decoder.
// master drives raw halls and observes state; slave is the decoder.
interface hall_commutation_decoder_if #(
    parameter int PERIOD_WIDTH = 16,
    parameter int COUNT_WIDTH  = 16
);
    logic [2:0]                     hall;
    logic [2:0]                     sector;
    logic                           hall_fault;
    logic                           direction;
    logic                           step_strobe;
    logic                           step_error;
    logic signed [COUNT_WIDTH-1:0]  edge_count;
    logic [PERIOD_WIDTH-1:0]        period;
    logic                           stalled;

    modport master (
        output hall,
        input  sector, hall_fault, direction,
        input  step_strobe, step_error,
        input  edge_count, period, stalled
    );

    modport slave (
        input  hall,
        output sector, hall_fault, direction,
        output step_strobe, step_error,
        output edge_count, period, stalled
    );
endinterface

// File: rtl/hall_commutation_decoder.sv
// BLDC hall sensor decoder: sync, debounce, sector decode,
// step classification, signed step count and step period.
module hall_commutation_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PERIOD_WIDTH    = 16,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    hall_commutation_decoder_if.slave hall_bus
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] P_MAX = '1;

    logic [2:0]                    sync1_q, sync2_q;
    logic [2:0]                    cand_q, cand_d;
    logic [DBW-1:0]                dbc_q, dbc_d;
    logic [2:0]                    acc_q, acc_d;
    logic [2:0]                    sector_q, sector_d;
    logic                          fault_q, fault_d;
    logic                          dir_q, dir_d;
    logic                          strobe_q, strobe_d;
    logic                          error_q, error_d;
    logic signed [COUNT_WIDTH-1:0] count_q, count_d;
    logic [PERIOD_WIDTH-1:0]       pcnt_q, pcnt_d;
    logic [PERIOD_WIDTH-1:0]       period_q, period_d;
    logic                          stalled_q, stalled_d;

    logic       accept;
    logic       both_valid;
    logic       fwd, rev;
    logic [2:0] new_sector, next_fwd, next_rev;

    function automatic logic [2:0] decode(input logic [2:0] code);
        case (code)
            3'b001:  decode = 3'd1;
            3'b011:  decode = 3'd2;
            3'b010:  decode = 3'd3;
            3'b110:  decode = 3'd4;
            3'b100:  decode = 3'd5;
            3'b101:  decode = 3'd6;
            default: decode = 3'd0;
        endcase
    endfunction

    // Two-flop synchronizer for the asynchronous hall lines
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= hall_bus.hall;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a code must be seen DEBOUNCE_CYCLES times in a row
    always_comb begin
        cand_d = cand_q;
        dbc_d  = dbc_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            dbc_d  = DBW'(1);
        end else if (dbc_q != DB_MAX) begin
            dbc_d = dbc_q + DBW'(1);
        end
    end

    assign accept = (dbc_q == DB_MAX) && (cand_q != acc_q);

    // Classify an accepted code against the current sector
    always_comb begin
        new_sector = decode(cand_q);
        next_fwd   = (sector_q == 3'd6) ? 3'd1 : sector_q + 3'd1;
        next_rev   = (sector_q == 3'd1) ? 3'd6 : sector_q - 3'd1;
        both_valid = (sector_q != 3'd0) && (new_sector != 3'd0);
        fwd        = accept && both_valid && (new_sector == next_fwd);
        rev        = accept && both_valid && (new_sector == next_rev);

        acc_d    = accept ? cand_q : acc_q;
        sector_d = accept ? new_sector : sector_q;
        fault_d  = accept ? (new_sector == 3'd0) : fault_q;
        strobe_d = fwd || rev;
        error_d  = accept && both_valid && !fwd && !rev;
        dir_d    = dir_q;
        count_d  = count_q;
        if (fwd) begin
            dir_d   = 1'b1;
            count_d = count_q + COUNT_WIDTH'(1);
        end else if (rev) begin
            dir_d   = 1'b0;
            count_d = count_q - COUNT_WIDTH'(1);
        end
    end

    // Period counter; a step beats saturation on the same edge
    always_comb begin
        pcnt_d    = (pcnt_q == P_MAX) ? P_MAX : pcnt_q + 1'b1;
        period_d  = period_q;
        stalled_d = stalled_q;
        if (strobe_d) begin
            pcnt_d    = PERIOD_WIDTH'(1);
            period_d  = stalled_q ? P_MAX : pcnt_q;
            stalled_d = 1'b0;
        end else if (pcnt_d == P_MAX) begin
            period_d  = P_MAX;
            stalled_d = 1'b1;
        end
    end

    // State registers for debounce, rotor state and period
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cand_q    <= 3'b000;
            dbc_q     <= '0;
            acc_q     <= 3'b000;
            sector_q  <= 3'd0;
            fault_q   <= 1'b0;
            dir_q     <= 1'b0;
            strobe_q  <= 1'b0;
            error_q   <= 1'b0;
            count_q   <= '0;
            pcnt_q    <= '0;
            period_q  <= P_MAX;
            stalled_q <= 1'b1;
        end else begin
            cand_q    <= cand_d;
            dbc_q     <= dbc_d;
            acc_q     <= acc_d;
            sector_q  <= sector_d;
            fault_q   <= fault_d;
            dir_q     <= dir_d;
            strobe_q  <= strobe_d;
            error_q   <= error_d;
            count_q   <= count_d;
            pcnt_q    <= pcnt_d;
            period_q  <= period_d;
            stalled_q <= stalled_d;
        end
    end

    assign hall_bus.sector      = sector_q;
    assign hall_bus.hall_fault  = fault_q;
    assign hall_bus.direction   = dir_q;
    assign hall_bus.step_strobe = strobe_q;
    assign hall_bus.step_error  = error_q;
    assign hall_bus.edge_count  = count_q;
    assign hall_bus.period      = period_q;
    assign hall_bus.stalled     = stalled_q;
endmodule

// File: tb/tb_hall_commutation_decoder.sv
// Bench for hall_commutation_decoder: directed hall sequences,
// expected step events queued and checked by per-DUT monitors.
module tb_hall_commutation_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hall_commutation_decoder_if #(
        .PERIOD_WIDTH(16), .COUNT_WIDTH(16)
    ) ifa ();
    hall_commutation_decoder_if #(
        .PERIOD_WIDTH(8), .COUNT_WIDTH(3)
    ) ifb ();

    hall_commutation_decoder #(
        .DEBOUNCE_CYCLES(4), .PERIOD_WIDTH(16), .COUNT_WIDTH(16)
    ) dut_a (
        .clock_i(clk), .reset_i(rst), .hall_bus(ifa)
    );

    hall_commutation_decoder #(
        .DEBOUNCE_CYCLES(2), .PERIOD_WIDTH(8), .COUNT_WIDTH(3)
    ) dut_b (
        .clock_i(clk), .reset_i(rst), .hall_bus(ifb)
    );

    typedef struct {
        bit err;
        int sector;
        bit dir;
        int cnt;
        int period;
        bit stalled;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    int  errors = 0;
    int  checks = 0;
    int  lat;

    task automatic chk(input string name,
                       input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_ev(input string tag, input ev_t e,
                          input logic strobe, input logic err,
                          input logic [2:0] sec, input logic dir,
                          input logic signed [31:0] cnt,
                          input logic [31:0] per, input logic st);
        chk({tag, "_excl"}, 32'(strobe & err), 0);
        chk({tag, "_kind"}, 32'(err), 32'(e.err));
        chk({tag, "_sector"}, 32'(sec), e.sector);
        chk({tag, "_dir"}, 32'(dir), 32'(e.dir));
        chk({tag, "_count"}, cnt, e.cnt);
        chk({tag, "_period"}, per, e.period);
        chk({tag, "_stalled"}, 32'(st), 32'(e.stalled));
    endtask

    task automatic exp_a(input bit err, input int s, input bit d,
                         input int c, input int p, input bit st);
        ev_t e;
        e = '{err, s, d, c, p, st};
        qa.push_back(e);
    endtask

    task automatic exp_b(input bit err, input int s, input bit d,
                         input int c, input int p, input bit st);
        ev_t e;
        e = '{err, s, d, c, p, st};
        qb.push_back(e);
    endtask

    task automatic drv_a(input logic [2:0] code, input int hold);
        ifa.hall = code;
        repeat (hold) @(negedge clk);
    endtask

    task automatic drv_b(input logic [2:0] code, input int hold);
        ifb.hall = code;
        repeat (hold) @(negedge clk);
    endtask

    // Monitor A: every strobe/error pulse must match the queue head
    always @(posedge clk) begin
        #1;
        if (!rst && (ifa.step_strobe || ifa.step_error)) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: strobe=%b error=%b sector=%0d",
                         ifa.step_strobe, ifa.step_error, ifa.sector);
            end else begin
                cmp_ev("a", qa.pop_front(), ifa.step_strobe,
                       ifa.step_error, ifa.sector, ifa.direction,
                       ifa.edge_count, 32'(ifa.period), ifa.stalled);
            end
        end
    end

    // Monitor B: same for the narrow-width instance
    always @(posedge clk) begin
        #1;
        if (!rst && (ifb.step_strobe || ifb.step_error)) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: strobe=%b error=%b sector=%0d",
                         ifb.step_strobe, ifb.step_error, ifb.sector);
            end else begin
                cmp_ev("b", qb.pop_front(), ifb.step_strobe,
                       ifb.step_error, ifb.sector, ifb.direction,
                       ifb.edge_count, 32'(ifb.period), ifb.stalled);
            end
        end
    end

    task automatic chk_reset_a(input string tag);
        chk({tag, "_sector"}, 32'(ifa.sector), 0);
        chk({tag, "_fault"}, 32'(ifa.hall_fault), 0);
        chk({tag, "_dir"}, 32'(ifa.direction), 0);
        chk({tag, "_strobe"}, 32'(ifa.step_strobe), 0);
        chk({tag, "_error"}, 32'(ifa.step_error), 0);
        chk({tag, "_count"}, ifa.edge_count, 0);
        chk({tag, "_period"}, 32'(ifa.period), 65535);
        chk({tag, "_stalled"}, 32'(ifa.stalled), 1);
    endtask

    initial begin
        ifa.hall = 3'b000;
        ifb.hall = 3'b000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_a("rst");
        chk("rst_b_period", 32'(ifb.period), 255);
        chk("rst_b_count", ifb.edge_count, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // forward rotation through all six sectors
        drv_a(3'b001, 100);
        chk("t1_first_sector", 32'(ifa.sector), 1);
        chk("t1_first_count", ifa.edge_count, 0);
        chk("t1_first_stalled", 32'(ifa.stalled), 1);
        exp_a(0, 2, 1, 1, 65535, 0); drv_a(3'b011, 100);
        exp_a(0, 3, 1, 2, 100, 0);   drv_a(3'b010, 100);
        exp_a(0, 4, 1, 3, 100, 0);   drv_a(3'b110, 100);
        exp_a(0, 5, 1, 4, 100, 0);   drv_a(3'b100, 100);
        exp_a(0, 6, 1, 5, 100, 0);   drv_a(3'b101, 100);
        exp_a(0, 1, 1, 6, 100, 0);   drv_a(3'b001, 100);
        chk("t1_count", ifa.edge_count, 6);
        chk("t1_dir", 32'(ifa.direction), 1);

        // glitch rejection and reverse step latency
        exp_a(0, 2, 1, 7, 100, 0); drv_a(3'b011, 100);
        exp_a(0, 3, 1, 8, 100, 0); drv_a(3'b010, 100);
        drv_a(3'b110, 3);
        exp_a(0, 2, 0, 7, 103, 0);
        ifa.hall = 3'b011;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && ifa.step_strobe) lat = i;
        end
        chk("t2_latency", lat, 7);
        repeat (89) @(negedge clk);
        chk("t2_sector", 32'(ifa.sector), 2);
        chk("t2_dir", 32'(ifa.direction), 0);

        // non-adjacent jump 1 -> 3
        exp_a(0, 1, 0, 6, 100, 0); drv_a(3'b001, 100);
        exp_a(1, 3, 0, 6, 100, 0); drv_a(3'b010, 100);
        chk("t3_sector", 32'(ifa.sector), 3);
        chk("t3_count", ifa.edge_count, 6);

        // reverse to sector 6 with 1 -> 6 wrap
        exp_a(0, 2, 0, 5, 200, 0); drv_a(3'b011, 100);
        exp_a(0, 1, 0, 4, 100, 0); drv_a(3'b001, 100);
        exp_a(0, 6, 0, 3, 100, 0); drv_a(3'b101, 100);

        // invalid code breaks the step chain
        drv_a(3'b111, 100);
        chk("t4_fault_on", 32'(ifa.hall_fault), 1);
        chk("t4_sector_none", 32'(ifa.sector), 0);
        drv_a(3'b001, 100);
        chk("t4_fault_off", 32'(ifa.hall_fault), 0);
        chk("t4_sector", 32'(ifa.sector), 1);
        chk("t4_count", ifa.edge_count, 3);

        // reverse down to a negative count
        exp_a(0, 6, 0, 2, 300, 0);  drv_a(3'b101, 100);
        exp_a(0, 5, 0, 1, 100, 0);  drv_a(3'b100, 100);
        exp_a(0, 4, 0, 0, 100, 0);  drv_a(3'b110, 100);
        exp_a(0, 3, 0, -1, 100, 0); drv_a(3'b010, 100);
        exp_a(0, 2, 0, -2, 100, 0); drv_a(3'b011, 100);
        exp_a(0, 1, 0, -3, 100, 0); drv_a(3'b001, 100);
        chk("t6_pre_count", ifa.edge_count, -3);

        // reset in the middle of a debounce
        ifa.hall = 3'b011;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        ifa.hall = 3'b000;
        @(posedge clk);
        #1;
        chk_reset_a("t6");
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_post_sector", 32'(ifa.sector), 0);
        chk("t6_post_count", ifa.edge_count, 0);

        // stall with 8-bit period, then 3-bit count wrap
        drv_b(3'b001, 300);
        chk("t5_sector", 32'(ifb.sector), 1);
        chk("t5_stalled", 32'(ifb.stalled), 1);
        chk("t5_period", 32'(ifb.period), 255);
        exp_b(0, 2, 1, 1, 255, 0); drv_b(3'b011, 50);
        exp_b(0, 3, 1, 2, 50, 0);  drv_b(3'b010, 50);
        exp_b(0, 4, 1, 3, 50, 0);  drv_b(3'b110, 50);
        exp_b(0, 5, 1, -4, 50, 0); drv_b(3'b100, 50);
        exp_b(0, 4, 0, 3, 50, 0);  drv_b(3'b110, 300);
        chk("t5_restall", 32'(ifb.stalled), 1);
        chk("t5_reperiod", 32'(ifb.period), 255);

        repeat (5) @(negedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
